fx_switch_ctrl: RTL and testbench

FX_SWITCH_CTRL -- requirements
Module: fx_switch_ctrl

---
 rtl/fx_switch_ctrl.sv | 131 +++++++++++++
 tb/tb_fx_switch_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fx_switch_ctrl.sv
// Effect-switch controller: debounces the effect switches and hides each
// enable change behind a fade-out / swap / fade-in of the audio gain, so an
// effect block is never switched while audio passes through it.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | gain at unity, enables match the debounced switches
//  FADE_OUT | gain stepping down once per frame, until it reaches 0
//  SWAP     | one clk at zero gain: load the enables from the switches
//  FADE_IN  | gain stepping up to unity; a new switch change turns it back
module fx_switch_ctrl #(
   parameter int RESOLUTION = 24,
   parameter int NUM_FX     = 2,
   parameter int DEBOUNCE   = 65536,
   parameter int STEP       = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         frame_tick,
   input  logic [NUM_FX-1:0]            sw,
   input  logic signed [RESOLUTION-1:0] data_in_L,
   input  logic signed [RESOLUTION-1:0] data_in_R,
   output logic signed [RESOLUTION-1:0] data_out_L,
   output logic signed [RESOLUTION-1:0] data_out_R,
   output logic [NUM_FX-1:0]            fx_en,
   output logic [7:0]                   gain,
   output logic                         busy
);

   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
   localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE - 1);
   localparam logic [7:0] GAIN_UNITY = 8'd128;
   localparam logic [7:0] GAIN_STEP  = 8'(STEP);
   localparam logic [7:0] GAIN_TOP   = 8'(128 - STEP);
   localparam int PW = RESOLUTION + 9;

   typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

   state_t            state;
   logic [NUM_FX-1:0] sw_sync1;
   logic [NUM_FX-1:0] sw_sync2;
   logic [NUM_FX-1:0] sw_cand;
   logic [NUM_FX-1:0] sw_stable;
   logic [CW-1:0]     db_cnt;

   // Synchronize, then accept a new switch pattern once it has held for the
   // debounce window; the down-counter restarts whenever the pattern moves.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_sync1  <= '0;
         sw_sync2  <= '0;
         sw_cand   <= '0;
         sw_stable <= '0;
         db_cnt    <= '0;
      end else begin
         sw_sync1 <= sw;
         sw_sync2 <= sw_sync1;
         if (sw_sync2 != sw_cand) begin
            sw_cand <= sw_sync2;
            db_cnt  <= DB_LOAD;
         end else if (sw_cand != sw_stable) begin
            if (db_cnt == '0)
               sw_stable <= sw_cand;
            else
               db_cnt <= db_cnt - CW'(1);
         end
      end
   end

   // Fade sequencer; fx_en is only ever loaded in SWAP, i.e. at zero gain.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         fx_en <= '0;
         gain  <= GAIN_UNITY;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sw_stable != fx_en) begin
                  state <= FADE_OUT;
                  busy  <= 1'b1;
               end
            end
            FADE_OUT: begin
               if (gain == 8'd0)
                  state <= SWAP;
               else if (frame_tick)
                  gain <= (gain <= GAIN_STEP) ? 8'd0 : gain - GAIN_STEP;
            end
            SWAP: begin
               fx_en <= sw_stable;
               state <= FADE_IN;
            end
            FADE_IN: begin
               if (sw_stable != fx_en)
                  state <= FADE_OUT;
               else if (gain == GAIN_UNITY) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (frame_tick)
                  gain <= (gain >= GAIN_TOP) ? GAIN_UNITY : gain + GAIN_STEP;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   logic signed [PW-1:0] ext_L;
   logic signed [PW-1:0] ext_R;
   logic signed [PW-1:0] ext_g;

   assign ext_L = PW'(data_in_L);
   assign ext_R = PW'(data_in_R);
   assign ext_g = $signed({{(RESOLUTION + 1){1'b0}}, gain});

   // Scale one sample per frame with the gain in force before this frame's step.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_L <= '0;
         data_out_R <= '0;
      end else if (frame_tick) begin
         data_out_L <= RESOLUTION'((ext_L * ext_g) >>> 7);
         data_out_R <= RESOLUTION'((ext_R * ext_g) >>> 7);
      end
   end

endmodule

// File: tb/tb_fx_switch_ctrl.sv
// Directed bench for fx_switch_ctrl with a short debounce window and
// frame ticks spaced eight clocks apart.
module tb_fx_switch_ctrl;

   localparam int RES = 24;
   localparam int NFX = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           frame_tick;
   logic [NFX-1:0] sw;
   logic [RES-1:0] data_in_L, data_in_R;
   logic [RES-1:0] data_out_L, data_out_R;
   logic [NFX-1:0] fx_en;
   logic [7:0]     gain;
   logic           busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [RES-1:0] in_l;
      logic [RES-1:0] in_r;
      logic [RES-1:0] exp_l;
      logic [RES-1:0] exp_r;
   } vec_t;

   vec_t vecs[4];

   fx_switch_ctrl #(.RESOLUTION(RES), .NUM_FX(NFX), .DEBOUNCE(4), .STEP(8)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .sw(sw),
      .data_in_L(data_in_L), .data_in_R(data_in_R),
      .data_out_L(data_out_L), .data_out_R(data_out_R),
      .fx_en(fx_en), .gain(gain), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_edge();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic wait_busy(input logic [NFX-1:0] old_en);
      int n = 0;
      while (busy !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("busy_rise", {31'd0, busy}, 32'd1);
      check("fx_en_before_swap", {30'd0, fx_en}, {30'd0, old_en});
      check("gain_before_fade", {24'd0, gain}, 32'd128);
   endtask

   // n ticks downward; returns right after the last tick edge
   task automatic fade_down(input int n, input int start);
      for (int k = 1; k <= n; k++) begin
         tick_edge();
         check("gain_down", {24'd0, gain}, 32'(start - 8 * k));
         if (k < n) repeat (7) step();
      end
   endtask

   task automatic fade_up(input int n, input int start);
      for (int k = 0; k < n; k++) begin
         tick_edge();
         check("gain_up", {24'd0, gain}, 32'(start + 8 * (k + 1)));
         if (start + 8 * k == 0) begin
            check("out_l_gain0", {8'd0, data_out_L}, 32'h0);
            check("out_r_gain0", {8'd0, data_out_R}, 32'h0);
         end
         if (start + 8 * k == 64) begin
            check("out_l_gain64", {8'd0, data_out_L}, 32'h3FFFFF);
            check("out_r_gain64", {8'd0, data_out_R}, 32'hC00000);
         end
         repeat (7) step();
      end
   endtask

   task automatic swap_check(input logic [NFX-1:0] old_en, input logic [NFX-1:0] new_en);
      step();
      check("swap_en_hold", {30'd0, fx_en}, {30'd0, old_en});
      check("swap_busy", {31'd0, busy}, 32'd1);
      step();
      check("swap_en_load", {30'd0, fx_en}, {30'd0, new_en});
      repeat (5) step();
   endtask

   initial begin
      vecs[0] = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000};
      vecs[1] = '{24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFF};
      vecs[2] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};
      vecs[3] = '{24'h000000, 24'h400000, 24'h000000, 24'h400000};

      reset = 1'b1; frame_tick = 1'b0; sw = '0;
      data_in_L = 24'h7FFFFF; data_in_R = 24'h800000;
      repeat (3) step();
      check("rst_gain", {24'd0, gain}, 32'd128);
      check("rst_fx_en", {30'd0, fx_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_l", {8'd0, data_out_L}, 32'd0);
      reset = 1'b0;
      repeat (20) step();
      check("idle_busy", {31'd0, busy}, 32'd0);

      // unity-gain pass-through, one clk after the tick
      for (int i = 0; i < 4; i++) begin
         data_in_L = vecs[i].in_l; data_in_R = vecs[i].in_r;
         tick_edge();
         check("vec_out_l", {8'd0, data_out_L}, {8'd0, vecs[i].exp_l});
         check("vec_out_r", {8'd0, data_out_R}, {8'd0, vecs[i].exp_r});
         repeat (7) step();
      end
      data_in_L = 24'h7FFFFF; data_in_R = 24'h800000;
      repeat (3) step();
      check("hold_out_l", {8'd0, data_out_L}, 32'h0);
      check("hold_out_r", {8'd0, data_out_R}, 32'h400000);

      // 3-clk glitch is rejected
      sw = 2'b01; repeat (3) step(); sw = 2'b00;
      repeat (20) step();
      check("glitch_busy", {31'd0, busy}, 32'd0);
      check("glitch_fx_en", {30'd0, fx_en}, 32'd0);
      check("glitch_gain", {24'd0, gain}, 32'd128);

      // full switch cycle 00 -> 01
      sw = 2'b01;
      wait_busy(2'b00);
      fade_down(16, 128);
      swap_check(2'b00, 2'b01);
      fade_up(16, 0);
      check("cycle_busy_drop", {31'd0, busy}, 32'd0);

      // back to 00 and reversal during fade-in at gain 64
      sw = 2'b00;
      wait_busy(2'b01);
      fade_down(16, 128);
      swap_check(2'b01, 2'b00);
      fade_up(8, 0);
      sw = 2'b01;
      repeat (12) step();
      check("rev_gain_hold", {24'd0, gain}, 32'd64);
      fade_down(8, 64);
      swap_check(2'b00, 2'b01);
      fade_up(16, 0);
      check("rev_busy_drop", {31'd0, busy}, 32'd0);
      check("rev_fx_en", {30'd0, fx_en}, 32'd1);

      // switch from 01 to 00 then 11 during fade-out: one fade, 11 applied
      sw = 2'b00;
      wait_busy(2'b01);
      fade_down(4, 128);
      repeat (7) step();
      sw = 2'b11;
      repeat (12) step();
      fade_down(12, 96);
      swap_check(2'b01, 2'b11);
      fade_up(16, 0);
      repeat (30) step();
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_fx_en", {30'd0, fx_en}, 32'd3);
      check("mid_gain", {24'd0, gain}, 32'd128);

      // reset during fade-out at gain 40
      sw = 2'b00;
      wait_busy(2'b11);
      fade_down(11, 128);
      reset = 1'b1;
      step();
      check("abort_gain", {24'd0, gain}, 32'd128);
      check("abort_fx_en", {30'd0, fx_en}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_out_l", {8'd0, data_out_L}, 32'd0);
      check("abort_out_r", {8'd0, data_out_R}, 32'd0);
      reset = 1'b0;
      repeat (20) step();
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_gain", {24'd0, gain}, 32'd128);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
